// File: rtl/cc_scheduler.sv
// Clock-compensation scheduler: periodically (or on cc_force) stalls the AXI source
// and asks data_controller to emit CC_LEN cycles of CC ordered sets.
module cc_scheduler #(
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 6,
    parameter int unsigned STAT_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             channel_init_finished,
    input  logic                             cc_force,
    output logic                             axi_ready,
    output logic                             cc_insert,
    output logic [$clog2(CC_LEN+1)-1:0]      cc_index,
    output logic                             cc_done,
    output logic [STAT_W-1:0]                cc_seq_count
);

    localparam int unsigned CNT_W = $clog2(CC_PERIOD);
    localparam int unsigned IDX_W = $clog2(CC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        INSERT
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  ready_q, ready_d;
    logic                  insert_q, insert_d;
    logic                  done_q, done_d;
    logic [STAT_W-1:0]     count_q, count_d;

    logic                  expire;
    logic                  last_cc;

    assign expire  = (period_q == CNT_W'(CC_PERIOD - 1));
    assign last_cc = (index_q == IDX_W'(CC_LEN - 1));

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        index_d  = '0;
        done_d   = 1'b0;
        count_d  = count_q;

        if (!channel_init_finished) begin
            // Losing the channel aborts any sequence silently; statistics survive.
            state_d  = IDLE;
            period_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = RUN;
                    period_d = '0;
                end
                RUN: begin
                    if (expire || cc_force) begin
                        state_d  = INSERT;
                        period_d = '0;
                    end else begin
                        period_d = period_q + CNT_W'(1);
                    end
                end
                INSERT: begin
                    // Period keeps running so spacing is measured start-to-start.
                    period_d = expire ? '0 : period_q + CNT_W'(1);
                    if (last_cc) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + STAT_W'(1);
                        end
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    period_d = '0;
                end
            endcase
        end

        ready_d  = (state_d == RUN);
        insert_d = (state_d == INSERT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            index_q  <= '0;
            ready_q  <= 1'b0;
            insert_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            index_q  <= index_d;
            ready_q  <= ready_d;
            insert_q <= insert_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign axi_ready    = ready_q;
    assign cc_insert    = insert_q;
    assign cc_index     = index_q;
    assign cc_done      = done_q;
    assign cc_seq_count = count_q;

endmodule

// File: tb/tb_cc_scheduler.sv
// Directed plus randomized bench for cc_scheduler against a time-based reference
// model (sequence start times and bring-up anchor, not a state machine).
module tb_cc_scheduler;

    localparam int unsigned CC_PERIOD = 20;
    localparam int unsigned CC_LEN    = 6;
    localparam int unsigned STAT_W    = 4;
    localparam int          MAXC      = (1 << STAT_W) - 1;

    logic                          clk;
    logic                          rst_n;
    logic                          channel_init_finished;
    logic                          cc_force;
    logic                          axi_ready;
    logic                          cc_insert;
    logic [$clog2(CC_LEN+1)-1:0]   cc_index;
    logic                          cc_done;
    logic [STAT_W-1:0]             cc_seq_count;

    int checks = 0;
    int errors = 0;

    // Model: t is the absolute edge count; a sequence occupies cycles
    // [m_seq, m_seq+CC_LEN) and cc_done appears at m_seq+CC_LEN.
    int m_t      = 0;
    int m_anchor = 0;
    int m_seq    = 0;
    bit m_up     = 0;
    bit m_have   = 0;
    int m_cnt    = 0;

    cc_scheduler #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN),
        .STAT_W    (STAT_W)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .channel_init_finished (channel_init_finished),
        .cc_force              (cc_force),
        .axi_ready             (axi_ready),
        .cc_insert             (cc_insert),
        .cc_index              (cc_index),
        .cc_done               (cc_done),
        .cc_seq_count          (cc_seq_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_ins();
        return m_have && ((m_t - m_seq) < CC_LEN);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic model_edge(input bit cif, input bit frc);
        bit busy;
        m_t++;
        if (!cif) begin
            m_up   = 0;
            m_have = 0;
        end else if (!m_up) begin
            m_up     = 1;
            m_anchor = m_t;
            m_have   = 0;
        end else begin
            busy = m_have && ((m_t - 1 - m_seq) < CC_LEN);
            if (!busy && ((m_t - m_anchor) == CC_PERIOD || frc)) begin
                m_seq    = m_t;
                m_anchor = m_t;
                m_have   = 1;
            end
            if (m_have && (m_t - m_seq) == CC_LEN && m_cnt < MAXC) m_cnt++;
        end
    endtask

    task automatic compare_all();
        bit ins;
        ins = m_ins();
        chk("axi_ready", 32'(axi_ready), 32'(m_up && !ins));
        chk("cc_insert", 32'(cc_insert), 32'(ins));
        chk("cc_index", 32'(cc_index), ins ? 32'(m_t - m_seq) : 32'd0);
        chk("cc_done", 32'(cc_done), 32'(m_have && (m_t - m_seq) == CC_LEN));
        chk("cc_seq_count", 32'(cc_seq_count), 32'(m_cnt));
    endtask

    task automatic step(input logic cif, input logic frc);
        channel_init_finished = cif;
        cc_force              = frc;
        @(posedge clk);
        model_edge(cif, frc);
        #1;
        compare_all();
        cc_force = 1'b0;
    endtask

    task automatic bring_up();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        int beats;
        int hold;

        rst_n                 = 1'b0;
        channel_init_finished = 1'b0;
        cc_force              = 1'b0;
        #1;
        chk("rst_axi_ready", 32'(axi_ready), 32'd0);
        chk("rst_cc_insert", 32'(cc_insert), 32'd0);
        chk("rst_cc_index", 32'(cc_index), 32'd0);
        chk("rst_cc_done", 32'(cc_done), 32'd0);
        chk("rst_cc_seq_count", 32'(cc_seq_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Bring-up, first sequence, dropped force, collision with expiry
        bring_up();
        chk("c0_ready", 32'(axi_ready), 32'd1);
        for (int c = 1; c <= 50; c++) begin
            step(1'b1, (c == 23) || (c == 40));
            if (c == 19) chk("c19_ready", 32'(axi_ready), 32'd1);
            if (c == 20) chk("c20_insert", 32'(cc_insert), 32'd1);
            if (c == 20) chk("c20_ready", 32'(axi_ready), 32'd0);
            if (c == 25) chk("c25_index", 32'(cc_index), 32'd5);
            if (c == 26) chk("c26_done", 32'(cc_done), 32'd1);
            if (c == 26) chk("c26_ready", 32'(axi_ready), 32'd1);
            if (c == 26) chk("c26_count", 32'(cc_seq_count), 32'd1);
            if (c == 27) chk("c27_no_extra", 32'(cc_insert), 32'd0);
            if (c == 40) chk("c40_insert", 32'(cc_insert), 32'd1);
            if (c == 46) chk("c46_count", 32'(cc_seq_count), 32'd2);
            if (c == 47) chk("c47_single_seq", 32'(cc_insert), 32'd0);
        end

        // Early force at cycle 5 shifts the schedule
        bring_up();
        for (int c = 1; c <= 27; c++) begin
            step(1'b1, c == 6);
            if (c == 6)  chk("f6_insert", 32'(cc_insert), 32'd1);
            if (c == 11) chk("f11_index", 32'(cc_index), 32'd5);
            if (c == 12) chk("f12_done", 32'(cc_done), 32'd1);
            if (c == 20) chk("f20_no_auto", 32'(cc_insert), 32'd0);
            if (c == 26) chk("f26_auto", 32'(cc_insert), 32'd1);
        end

        // Abort mid-sequence, then restart the period
        bring_up();
        for (int c = 1; c <= 23; c++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("abort_ready", 32'(axi_ready), 32'd0);
        chk("abort_insert", 32'(cc_insert), 32'd0);
        chk("abort_index", 32'(cc_index), 32'd0);
        chk("abort_count", 32'(cc_seq_count), 32'd3);
        step(1'b0, 1'b0);
        chk("abort_no_done", 32'(cc_done), 32'd0);
        step(1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            step(1'b1, 1'b0);
            if (c == 19) chk("restart_c19", 32'(cc_insert), 32'd0);
            if (c == 20) chk("restart_c20", 32'(cc_insert), 32'd1);
        end

        // Saturation
        for (int i = 0; i < 20 * CC_PERIOD; i++) step(1'b1, 1'b0);
        chk("saturated_count", 32'(cc_seq_count), 32'd15);

        // Asynchronous reset mid-INSERT
        for (int i = 0; i < 2 * CC_PERIOD && !m_ins(); i++) step(1'b1, 1'b0);
        chk("pre_reset_insert", 32'(cc_insert), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_insert", 32'(cc_insert), 32'd0);
        chk("async_ready", 32'(axi_ready), 32'd0);
        chk("async_count", 32'(cc_seq_count), 32'd0);
        chk("async_index", 32'(cc_index), 32'd0);
        m_up   = 0;
        m_have = 0;
        m_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Stall integrity: 50-beat frame, valid held high, random forces
        bring_up();
        beats = 0;
        for (int k = 0; k < 300 && beats < 50; k++) begin
            if (axi_ready === 1'b1) beats++;
            step(1'b1, $urandom_range(0, 7) == 0);
        end
        chk("stall_beats", 32'(beats), 32'd50);

        // Random traffic
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0 && $urandom_range(0, 127) == 0) hold = $urandom_range(1, 4);
            step(hold == 0, $urandom_range(0, 11) == 0);
            if (hold > 0) hold--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_scheduler.md
# cc_scheduler

Clock-compensation (CC) scheduler for the Aurora 8b/10b transmit channel. It sits between `channel_init` and `data_controller` and runs only while the channel is initialised. A period counter requests a CC sequence every `CC_PERIOD` cycles, and `cc_force` can request one early. During each sequence the block stalls the AXI-stream source and tells `data_controller` to drive CC ordered sets on all lanes for `CC_LEN` cycles.

## Interface
Parameters:
- `CC_PERIOD`, default 5000: cycles from the start of one CC sequence to the start of the next. Must satisfy CC_PERIOD > CC_LEN + 1.
- `CC_LEN`, default 6: cycles per CC sequence. Must be ≥ 1.
- `STAT_W`, default 16: width of the sequence statistics counter.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `channel_init_finished` in 1: level from `channel_init`; high means the channel is up.
- `cc_force` in 1: single-cycle request for an immediate CC sequence.
- `axi_ready` out 1: registered AXI-stream ready toward the source; high only in state RUN.
- `cc_insert` out 1: registered; high while `data_controller` must send CC ordered sets.
- `cc_index` out $clog2(CC_LEN+1): registered; position of the current cycle within the sequence.
- `cc_done` out 1: registered one-cycle pulse on the cycle after the last CC cycle.
- `cc_seq_count` out STAT_W: number of completed sequences; saturates at all-ones.

## Operation
- States: IDLE, RUN, INSERT. All outputs are registered and are pure functions of state and counters.
- Reset values: state IDLE, `period_cnt`=0, `axi_ready`=0, `cc_insert`=0, `cc_index`=0, `cc_done`=0, `cc_seq_count`=0.
- `period_cnt` width: $clog2(CC_PERIOD). It counts 0..CC_PERIOD-1, then wraps to 0.
- IDLE:
  - `axi_ready`=0, `cc_insert`=0, `period_cnt` held at 0.
  - `channel_init_finished`=1 sampled → RUN.
- RUN:
  - `axi_ready`=1; `period_cnt` increments every cycle.
  - Transition to INSERT when `period_cnt`==CC_PERIOD-1 or `cc_force`=1. On that edge `period_cnt` loads 0.
  - If expiry and `cc_force` fall in the same cycle, exactly one sequence is started.
- INSERT:
  - `axi_ready`=0, `cc_insert`=1. `cc_index` starts at 0 on entry and increments each cycle.
  - `period_cnt` keeps counting, so the period is measured start-to-start.
  - On the cycle with `cc_index`==CC_LEN-1:
    - next state RUN, `cc_index`→0;
    - `cc_done` pulses on the next cycle;
    - `cc_seq_count` increments on that same edge unless already all-ones.
  - `cc_force` asserted in INSERT is dropped: not queued, not counted.
- `channel_init_finished` falling, in any state:
  - next cycle is IDLE with `axi_ready`=0, `cc_insert`=0, `cc_index`=0, `period_cnt`=0;
  - an aborted sequence does not pulse `cc_done` and does not increment `cc_seq_count`;
  - `cc_seq_count` is otherwise preserved; only `rst_n` clears it.
- `rst_n` asserted mid-sequence: every output returns to its reset value immediately (asynchronously).
- CC is allowed mid-frame. The AXI source holds its beat while `axi_ready`=0, so no data is lost and no frame is truncated.

## Timing
- Cycle numbering: edge E0 samples `channel_init_finished`=1.
  - `axi_ready`=1 from E0.
  - The first automatic INSERT begins at E0+CC_PERIOD: `axi_ready` falls and `cc_insert` rises in the same cycle.
- Sequence shape:
  - `cc_insert` is high for exactly CC_LEN cycles, with `cc_index` stepping 0..CC_LEN-1.
  - `axi_ready` returns to 1 on the same edge that `cc_insert` falls.
  - `cc_done` is high during the first RUN cycle after the sequence.
- `cc_force` latency: forced high in RUN cycle N → `cc_insert` high from cycle N+1.
- Later automatic sequences start every CC_PERIOD cycles, counted from the start of the previous sequence, forced or not.
- `axi_ready` and `cc_insert` are never high in the same cycle. In RUN, INSERT and after the first edge out of reset, exactly one of them is high; in IDLE both are low.

## Test plan
Use CC_PERIOD=20, CC_LEN=6, STAT_W=4 unless stated.
- **Bring-up and first sequence.** Release reset, raise `channel_init_finished` at edge 0 → `axi_ready`=1 in cycles 0-19. `cc_insert`=1 in cycles 20-25 with `cc_index` 0..5. `cc_done`=1 in cycle 26, where `cc_seq_count`=1 and `axi_ready`=1. Next `cc_insert` starts at cycle 40.
- **Force and collision.**
  - Pulse `cc_force` at cycle 5 → INSERT spans cycles 6-11; next automatic sequence starts at cycle 26.
  - Pulse `cc_force` in cycle 39, coinciding with expiry → one sequence only, in cycles 40-45.
- **Force dropped.** Pulse `cc_force` during INSERT at cycle 22 → sequence still ends at cycle 25; no extra sequence follows; `cc_seq_count` increments by 1 only.
- **Abort.** Drop `channel_init_finished` at cycle 23 → cycle 24 is IDLE with all outputs 0; `cc_done` does not pulse; `cc_seq_count` unchanged. Re-raise it → the period restarts from 0.
- **Saturation and async reset.**
  - Run 20 sequences with STAT_W=4 → `cc_seq_count` stays at 15.
  - Assert `rst_n`=0 mid-INSERT, between clock edges → `cc_insert`, `axi_ready` and `cc_seq_count` go to 0 immediately.
- **Stall integrity.** Drive a 50-beat AXI frame continuously → every beat is accepted only on cycles with `axi_ready`=1, and the accepted count is exactly 50.
